// File: rtl/encoder_4to2_seq.sv
// ---------------------------------------------------------------------------
// encoder_4to2_seq
//
// Sequential 4-to-2 priority encoder with a pending-request mask and a
// valid/ready output handshake.
//
// Handshake: the block presents an index on out with valid=1. The index is
// consumed on a rising edge where valid && ready are both high. While
// valid=1 and ready=0, out and valid stay stable. ready is ignored while
// valid=0. After a transfer the next pending index, if any, is presented in
// the very next cycle with no bubble.
//
// Parameters
//   PRIO_HIGH  1: pend[3] has the highest priority; 0: pend[0] has the highest
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         request capture enable (in is ignored when 0)
//   in[3:0]    request lines, one cycle per event, multi-hot allowed
//   ready      consumer accepts the presented index
//   out[1:0]   presented index (holds its last value when idle)
//   valid      out holds a request awaiting acceptance
//   drop       one-cycle pulse: a request hit a bit that was already pending
//   pend[3:0]  registered pending-request mask
//   dbg_state  current FSM state (0 = IDLE, 1 = HOLD)
// ---------------------------------------------------------------------------
module encoder_4to2_seq #(
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] in,
  input  logic       ready,
  output logic [1:0] out,
  output logic       valid,
  output logic       drop,
  output logic [3:0] pend,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q;
  logic [1:0] out_q;
  logic       valid_q;
  logic       drop_q;
  logic [3:0] pend_q;

  logic [1:0] sel_idx;
  logic       take;
  logic [3:0] clr_mask;
  logic [3:0] set_mask;
  logic [3:0] pend_d;
  logic       drop_d;

  // Priority selection looks only at the registered mask, so a request
  // captured at one edge is presented at the following edge at the earliest.
  always_comb begin
    sel_idx = 2'd0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (pend_q[i]) sel_idx = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (pend_q[i]) sel_idx = 2'(i);
      end
    end
  end

  // A pending bit is taken when IDLE, or when HOLD and the current index
  // is being accepted.
  always_comb begin
    take     = (pend_q != 4'b0000) && ((state_q == IDLE) || ready);
    clr_mask = take ? (4'b0001 << sel_idx) : 4'b0000;
    set_mask = en ? in : 4'b0000;
    // Set is applied after clear so a new request on a bit being taken wins.
    pend_d   = (pend_q & ~clr_mask) | set_mask;
    // Lost only if the bit stays pending; several lost bits give one pulse.
    drop_d   = |(set_mask & pend_q & ~clr_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= 2'b00;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      pend_q  <= 4'b0000;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      case (state_q)
        IDLE: begin
          if (take) begin
            out_q   <= sel_idx;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            if (take) begin
              out_q <= sel_idx;
            end else begin
              // out keeps its last value when the queue drains.
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign drop      = drop_q;
  assign pend      = pend_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// ---------------------------------------------------------------------------
// tb_encoder_4to2_seq
//
// Directed bench for encoder_4to2_seq. Two instances share the same stimulus:
// dut_hi (PRIO_HIGH=1) and dut_lo (PRIO_HIGH=0). Each cycle's observation is
// packed as {valid, out[1:0], pend[3:0], drop}; expected values are written
// by hand per step. Stimulus words are {en, in[3:0], ready}.
// ---------------------------------------------------------------------------
module tb_encoder_4to2_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req_in;
  logic       ready;

  logic [1:0] out_hi, out_lo;
  logic       valid_hi, valid_lo;
  logic       drop_hi, drop_lo;
  logic [3:0] pend_hi, pend_lo;
  logic       dbg_hi, dbg_lo;

  logic [7:0] obs_hi, obs_lo;
  assign obs_hi = {valid_hi, out_hi, pend_hi, drop_hi};
  assign obs_lo = {valid_lo, out_lo, pend_lo, drop_lo};

  int n_checks = 0;
  int n_fail   = 0;

  encoder_4to2_seq #(.PRIO_HIGH(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .in(req_in), .ready(ready),
    .out(out_hi), .valid(valid_hi), .drop(drop_hi), .pend(pend_hi),
    .dbg_state(dbg_hi)
  );

  encoder_4to2_seq #(.PRIO_HIGH(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .in(req_in), .ready(ready),
    .out(out_lo), .valid(valid_lo), .drop(drop_lo), .pend(pend_lo),
    .dbg_state(dbg_lo)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    req_in = 4'b1111;
    ready  = 1'b1;
    tick();
    n_checks++;
    if (obs_hi !== 8'b0_00_0000_0) begin
      n_fail++; $display("FAIL reset hi: got %b expected %b", obs_hi, 8'b0_00_0000_0);
    end
    n_checks++;
    if (obs_lo !== 8'b0_00_0000_0) begin
      n_fail++; $display("FAIL reset lo: got %b expected %b", obs_lo, 8'b0_00_0000_0);
    end
    tick();
    en = 1'b0; req_in = 4'b0000; ready = 1'b0;
    rst_n = 1'b1;
    tick();
    // Requests driven during reset must not have been captured.
    n_checks++;
    if (obs_hi !== 8'b0_00_0000_0) begin
      n_fail++; $display("FAIL reset_release hi: got %b expected %b", obs_hi, 8'b0_00_0000_0);
    end
    n_checks++;
    if (obs_lo !== 8'b0_00_0000_0) begin
      n_fail++; $display("FAIL reset_release lo: got %b expected %b", obs_lo, 8'b0_00_0000_0);
    end
    n_checks++;
    if (dbg_hi !== 1'b0) begin
      n_fail++; $display("FAIL reset_state hi: got %b expected 0", dbg_hi);
    end
  endtask

  task automatic test_single();
    logic [5:0] stim [0:2];
    logic [7:0] ehi  [0:2];
    logic [7:0] elo  [0:2];
    stim = '{6'b1_0100_1, 6'b0_0000_1, 6'b0_0000_1};
    ehi  = '{8'b0_00_0100_0, 8'b1_10_0000_0, 8'b0_10_0000_0};
    elo  = '{8'b0_00_0100_0, 8'b1_10_0000_0, 8'b0_10_0000_0};
    for (int k = 0; k < 3; k++) begin
      {en, req_in, ready} = stim[k];
      tick();
      n_checks++;
      if (obs_hi !== ehi[k]) begin
        n_fail++; $display("FAIL single[%0d] hi: got %b expected %b", k, obs_hi, ehi[k]);
      end
      n_checks++;
      if (obs_lo !== elo[k]) begin
        n_fail++; $display("FAIL single[%0d] lo: got %b expected %b", k, obs_lo, elo[k]);
      end
    end
  endtask

  task automatic test_priority();
    logic [5:0] stim [0:4];
    logic [7:0] ehi  [0:4];
    logic [7:0] elo  [0:4];
    stim = '{6'b1_1011_1, 6'b0_0000_1, 6'b0_0000_1, 6'b0_0000_1, 6'b0_0000_1};
    ehi  = '{8'b0_10_1011_0, 8'b1_11_0011_0, 8'b1_01_0001_0, 8'b1_00_0000_0, 8'b0_00_0000_0};
    elo  = '{8'b0_10_1011_0, 8'b1_00_1010_0, 8'b1_01_1000_0, 8'b1_11_0000_0, 8'b0_11_0000_0};
    for (int k = 0; k < 5; k++) begin
      {en, req_in, ready} = stim[k];
      tick();
      n_checks++;
      if (obs_hi !== ehi[k]) begin
        n_fail++; $display("FAIL priority[%0d] hi: got %b expected %b", k, obs_hi, ehi[k]);
      end
      n_checks++;
      if (obs_lo !== elo[k]) begin
        n_fail++; $display("FAIL priority[%0d] lo: got %b expected %b", k, obs_lo, elo[k]);
      end
    end
  endtask

  task automatic test_prio_low();
    logic [5:0] stim [0:3];
    logic [7:0] ehi  [0:3];
    logic [7:0] elo  [0:3];
    stim = '{6'b1_1010_1, 6'b0_0000_1, 6'b0_0000_1, 6'b0_0000_1};
    ehi  = '{8'b0_00_1010_0, 8'b1_11_0010_0, 8'b1_01_0000_0, 8'b0_01_0000_0};
    elo  = '{8'b0_11_1010_0, 8'b1_01_1000_0, 8'b1_11_0000_0, 8'b0_11_0000_0};
    for (int k = 0; k < 4; k++) begin
      {en, req_in, ready} = stim[k];
      tick();
      n_checks++;
      if (obs_hi !== ehi[k]) begin
        n_fail++; $display("FAIL prio_low[%0d] hi: got %b expected %b", k, obs_hi, ehi[k]);
      end
      n_checks++;
      if (obs_lo !== elo[k]) begin
        n_fail++; $display("FAIL prio_low[%0d] lo: got %b expected %b", k, obs_lo, elo[k]);
      end
    end
  endtask

  // Stall in HOLD, accumulate, re-request the presented index, then drain.
  task automatic test_hold();
    logic [5:0] stim [0:10];
    logic [7:0] ehi  [0:10];
    logic [7:0] elo  [0:10];
    stim = '{6'b1_0010_0, 6'b0_0000_0, 6'b1_0001_0, 6'b0_0000_0, 6'b0_0000_0,
             6'b0_0000_0, 6'b0_0000_0, 6'b1_0010_0, 6'b0_0000_1, 6'b0_0000_1,
             6'b0_0000_1};
    ehi  = '{8'b0_01_0010_0, 8'b1_01_0000_0, 8'b1_01_0001_0, 8'b1_01_0001_0, 8'b1_01_0001_0,
             8'b1_01_0001_0, 8'b1_01_0001_0, 8'b1_01_0011_0, 8'b1_01_0001_0, 8'b1_00_0000_0,
             8'b0_00_0000_0};
    elo  = '{8'b0_11_0010_0, 8'b1_01_0000_0, 8'b1_01_0001_0, 8'b1_01_0001_0, 8'b1_01_0001_0,
             8'b1_01_0001_0, 8'b1_01_0001_0, 8'b1_01_0011_0, 8'b1_00_0010_0, 8'b1_01_0000_0,
             8'b0_01_0000_0};
    for (int k = 0; k < 11; k++) begin
      {en, req_in, ready} = stim[k];
      tick();
      n_checks++;
      if (obs_hi !== ehi[k]) begin
        n_fail++; $display("FAIL hold[%0d] hi: got %b expected %b", k, obs_hi, ehi[k]);
      end
      n_checks++;
      if (obs_lo !== elo[k]) begin
        n_fail++; $display("FAIL hold[%0d] lo: got %b expected %b", k, obs_lo, elo[k]);
      end
    end
  endtask

  task automatic test_drop();
    logic [5:0] stim [0:10];
    logic [7:0] ehi  [0:10];
    logic [7:0] elo  [0:10];
    stim = '{6'b1_1000_0, 6'b0_0000_0, 6'b1_0010_0, 6'b1_0010_0, 6'b0_0000_0,
             6'b0_1111_0, 6'b1_0011_0, 6'b0_0000_0, 6'b0_0000_1, 6'b0_0000_1,
             6'b0_0000_1};
    ehi  = '{8'b0_00_1000_0, 8'b1_11_0000_0, 8'b1_11_0010_0, 8'b1_11_0010_1, 8'b1_11_0010_0,
             8'b1_11_0010_0, 8'b1_11_0011_1, 8'b1_11_0011_0, 8'b1_01_0001_0, 8'b1_00_0000_0,
             8'b0_00_0000_0};
    elo  = '{8'b0_01_1000_0, 8'b1_11_0000_0, 8'b1_11_0010_0, 8'b1_11_0010_1, 8'b1_11_0010_0,
             8'b1_11_0010_0, 8'b1_11_0011_1, 8'b1_11_0011_0, 8'b1_00_0010_0, 8'b1_01_0000_0,
             8'b0_01_0000_0};
    for (int k = 0; k < 11; k++) begin
      {en, req_in, ready} = stim[k];
      tick();
      n_checks++;
      if (obs_hi !== ehi[k]) begin
        n_fail++; $display("FAIL drop[%0d] hi: got %b expected %b", k, obs_hi, ehi[k]);
      end
      n_checks++;
      if (obs_lo !== elo[k]) begin
        n_fail++; $display("FAIL drop[%0d] lo: got %b expected %b", k, obs_lo, elo[k]);
      end
    end
  endtask

  // Same-cycle set and clear on one bit (from IDLE and from HOLD), then
  // ready while idle.
  task automatic test_set_clear();
    logic [5:0] stim [0:6];
    logic [7:0] ehi  [0:6];
    logic [7:0] elo  [0:6];
    stim = '{6'b1_0100_0, 6'b1_0100_0, 6'b0_0000_0, 6'b1_0100_1, 6'b0_0000_1,
             6'b0_0000_1, 6'b0_0000_1};
    ehi  = '{8'b0_00_0100_0, 8'b1_10_0100_0, 8'b1_10_0100_0, 8'b1_10_0100_0, 8'b1_10_0000_0,
             8'b0_10_0000_0, 8'b0_10_0000_0};
    elo  = '{8'b0_01_0100_0, 8'b1_10_0100_0, 8'b1_10_0100_0, 8'b1_10_0100_0, 8'b1_10_0000_0,
             8'b0_10_0000_0, 8'b0_10_0000_0};
    for (int k = 0; k < 7; k++) begin
      {en, req_in, ready} = stim[k];
      tick();
      n_checks++;
      if (obs_hi !== ehi[k]) begin
        n_fail++; $display("FAIL set_clear[%0d] hi: got %b expected %b", k, obs_hi, ehi[k]);
      end
      n_checks++;
      if (obs_lo !== elo[k]) begin
        n_fail++; $display("FAIL set_clear[%0d] lo: got %b expected %b", k, obs_lo, elo[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] stim [0:1];
    logic [7:0] eall [0:1];
    logic [5:0] post [0:4];
    logic [7:0] epst [0:4];
    stim = '{6'b1_1000_0, 6'b1_0110_0};
    eall = '{8'b0_10_1000_0, 8'b1_11_0110_0};
    for (int k = 0; k < 2; k++) begin
      {en, req_in, ready} = stim[k];
      tick();
      n_checks++;
      if (obs_hi !== eall[k]) begin
        n_fail++; $display("FAIL async_setup[%0d] hi: got %b expected %b", k, obs_hi, eall[k]);
      end
      n_checks++;
      if (obs_lo !== eall[k]) begin
        n_fail++; $display("FAIL async_setup[%0d] lo: got %b expected %b", k, obs_lo, eall[k]);
      end
    end
    // Assert reset between edges with requests still being driven.
    #2;
    rst_n = 1'b0;
    en = 1'b1; req_in = 4'b0110; ready = 1'b1;
    #1;
    n_checks++;
    if (obs_hi !== 8'b0_00_0000_0) begin
      n_fail++; $display("FAIL async_assert hi: got %b expected %b", obs_hi, 8'b0_00_0000_0);
    end
    n_checks++;
    if (obs_lo !== 8'b0_00_0000_0) begin
      n_fail++; $display("FAIL async_assert lo: got %b expected %b", obs_lo, 8'b0_00_0000_0);
    end
    tick();
    #2;
    en = 1'b0; req_in = 4'b0000;
    rst_n = 1'b1;
    // No valid after release until a new request, then capture resumes.
    post = '{6'b0_0000_1, 6'b0_0000_1, 6'b1_0001_1, 6'b0_0000_1, 6'b0_0000_1};
    epst = '{8'b0_00_0000_0, 8'b0_00_0000_0, 8'b0_00_0001_0, 8'b1_00_0000_0, 8'b0_00_0000_0};
    for (int k = 0; k < 5; k++) begin
      {en, req_in, ready} = post[k];
      tick();
      n_checks++;
      if (obs_hi !== epst[k]) begin
        n_fail++; $display("FAIL async_release[%0d] hi: got %b expected %b", k, obs_hi, epst[k]);
      end
      n_checks++;
      if (obs_lo !== epst[k]) begin
        n_fail++; $display("FAIL async_release[%0d] lo: got %b expected %b", k, obs_lo, epst[k]);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    req_in = 4'b0000;
    ready  = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_prio_low();
    test_hold();
    test_drop();
    test_set_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
